// File: rtl/spi_master_x.sv
// Full-duplex SPI master, CPOL/CPHA per frame; done lands (2*DATA_W+1)*HALF_DIV cycles after cs_n falls.
// A start request is ignored while busy. Define SPI_MASTER_X_LSB_FIRST_EN to add the lsb_first input.
module spi_master_x #(
  parameter int DATA_W   = 8,
  parameter int HALF_DIV = 2,
  parameter int CS_GAP   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_X_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_GAP} state_e;

  localparam int EDGES   = 2 * DATA_W;
  localparam int EDGE_W  = $clog2(EDGES);
  localparam int CNT_MAX = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(CS_GAP - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic                cpha_q, cpha_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic                tick, gap_end, lsb_sel, lsb_start;
  logic [DATA_W-1:0]   start_word;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    for (int i = 0; i < DATA_W; i++) bit_rev[i] = v[DATA_W-1-i];
  endfunction

`ifdef SPI_MASTER_X_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_sel   = lsb_q;
  assign lsb_start = lsb_first;

  always_comb begin
    lsb_d = lsb_q;
    if (state_q == S_IDLE && start) lsb_d = lsb_first;
  end

  always_ff @(posedge clk) begin
    if (reset) lsb_q <= 1'b0;
    else       lsb_q <= lsb_d;
  end
`else
  assign lsb_sel   = 1'b0;
  assign lsb_start = 1'b0;
`endif

  // Shifting always happens from the MSB end; LSB-first frames are reversed at the edges.
  assign start_word = lsb_start ? bit_rev(tx_data) : tx_data;
  assign tick       = (cnt_q == DIV_LAST);
  assign gap_end    = (cnt_q == GAP_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LEAD;
      S_LEAD:  if (tick) state_d = S_XFER;
      S_XFER:  if (tick && edge_q == EDGE_LAST) state_d = S_TRAIL;
      S_TRAIL: if (tick) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    edge_d    = edge_q;
    cpha_d    = cpha_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    if (state_q == S_IDLE || state_d != state_q || (state_q == S_XFER && tick))
      cnt_d = '0;
    else
      cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        sclk_d = cpol;
        if (start) begin
          cpha_d  = cpha;
          cs_n_d  = 1'b0;
          edge_d  = '0;
          rx_sh_d = '0;
          // CPHA=0 presents the first bit as cs_n falls; CPHA=1 waits for edge 0.
          if (cpha) begin
            tx_sh_d = start_word;
            mosi_d  = 1'b0;
          end else begin
            tx_sh_d = {start_word[DATA_W-2:0], 1'b0};
            mosi_d  = start_word[DATA_W-1];
          end
        end
      end
      S_LEAD, S_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (edge_q != EDGE_LAST) edge_d = edge_q + EDGE_W'(1);
          if (edge_q[0] == cpha_q) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
          end else if (edge_q != EDGE_LAST) begin
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_TRAIL: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = lsb_sel ? bit_rev(rx_sh_q) : rx_sh_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      edge_q    <= '0;
      cpha_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      cpha_q    <= cpha_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_x.sv
// Scoreboarded bench for spi_master_x with a behavioural SPI slave and optional loopback.
module tb_spi_master_x;
  localparam int DW  = 8;
  localparam int HD  = 2;
  localparam int GAP = 2;
  localparam int FRAME_LEN = (2 * DW + 1) * HD;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] rx_data;
  logic busy, done, sclk, cs_n, mosi, miso;
  logic miso_s = 1'b0;
  bit   loop_act = 1'b0;
  bit   lsb_drv = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

`ifdef SPI_MASTER_X_LSB_FIRST_EN
  logic lsb_first;
  assign lsb_first = lsb_drv;
`endif

  assign miso = loop_act ? mosi : miso_s;

  spi_master_x #(.DATA_W(DW), .HALF_DIV(HD), .CS_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .cpol(cpol), .cpha(cpha),
`ifdef SPI_MASTER_X_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  typedef struct {
    logic [DW-1:0] rx_exp;
    logic [DW-1:0] rcv_exp;
    logic [DW-1:0] sw;
    bit            cpol;
    bit            cpha;
    bit            loop;
    int            t0;
    int            done_cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
    for (int i = 0; i < DW; i++) rev[i] = v[DW-1-i];
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Expected results follow from the frame content alone: loopback returns tx_data,
  // otherwise the slave's word (sent MSB first on the wire) reassembled in the frame's bit order.
  task automatic push_frame(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input bit cp,
                            input bit ch, input bit lp, input bit lsb, input int t0);
    exp_t e;
    e.cpol     = cp;
    e.cpha     = ch;
    e.loop     = lp;
    e.sw       = sw;
    e.t0       = t0;
    e.done_cyc = t0 + FRAME_LEN;
    e.rx_exp   = lp ? tx : (lsb ? rev(sw) : sw);
    e.rcv_exp  = lsb ? rev(tx) : tx;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input bit cp,
                       input bit ch, input bit lp, input bit lsb, output int t0);
    wait_idle();
    tx_data = tx;
    cpol    = cp;
    cpha    = ch;
    lsb_drv = lsb;
    step();
    chk("idle_sclk_follows_cpol", sclk, cp);
    start = 1'b1;
    t0 = cyc + 1;
    push_frame(tx, sw, cp, ch, lp, lsb, t0);
    step();
    start = 1'b0;
  endtask

  // Monitor plus slave model; all sampling happens on the falling clk edge.
  exp_t          cur;
  bit            active = 1'b0;
  int            k = 0, bi = 0;
  logic [DW-1:0] rcv = '0;
  logic          prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic          prev_busy = 1'b0, prev_done = 1'b0;
  bit            bf_valid = 1'b0;
  int            bf_exp = 0;

  always @(negedge clk) begin
    exp_t e;
    bit toggled, drive_edge;
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: cs_n fell at cycle %0d, required no frame", cyc);
      end else begin
        chk("cs_fall_cycle", cyc, sb_q[0].t0);
        chk("busy_at_cs_fall", busy, 1);
        cur      = sb_q[0];
        active   = 1'b1;
        k        = 0;
        bi       = 0;
        rcv      = '0;
        loop_act = cur.loop;
        if (!cur.cpha) begin
          miso_s = cur.sw[DW-1];
          bi     = 1;
        end
      end
    end else if (prev_cs === 1'b0 && cs_n === 1'b0 && active) begin
      toggled    = (sclk !== prev_sclk);
      drive_edge = toggled && ((k % 2) != int'(cur.cpha)) && (k != 2 * DW - 1);
      if (mosi !== prev_mosi) chk("mosi_moves_on_drive_edge", drive_edge, 1);
      if (toggled) begin
        if ((k % 2) == int'(cur.cpha)) begin
          rcv = {rcv[DW-2:0], mosi};
        end else if (drive_edge) begin
          miso_s = cur.sw[DW-1-bi];
          bi++;
        end
        k++;
      end
    end
    if (cs_n === 1'b1) active = 1'b0;

    if (done === 1'b1) begin
      chk("done_single_cycle", prev_done, 0);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done at cycle %0d, required none", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("rx_data", rx_data, e.rx_exp);
        chk("slave_received", rcv, e.rcv_exp);
        chk("sclk_idle_after_frame", sclk, e.cpol);
        chk("cs_n_high_at_done", cs_n, 1);
        bf_exp   = cyc + GAP;
        bf_valid = 1'b1;
      end
    end

    if (prev_busy === 1'b1 && busy === 1'b0 && bf_valid) begin
      chk("busy_fall_cycle", cyc, bf_exp);
      bf_valid = 1'b0;
    end else if (bf_valid && cyc > bf_exp) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_fall_timeout: busy=%b at cycle %0d, required 0 at %0d", busy, cyc, bf_exp);
      bf_valid = 1'b0;
    end

    prev_cs   = cs_n;
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_busy = busy;
    prev_done = done;
  end

  initial begin
    int t0, t0b;
    logic [DW-1:0] tx2, sw2;
    bit cp2, ch2;

    repeat (3) step();
    chk("reset_cs_n", cs_n, 1);
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rx_data", rx_data, 0);
    reset = 1'b0;
    step();

    issue(8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, t0);   // mode 0, loopback
    issue(8'hC3, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, t0);   // mode 3, slave 0x3C
    issue(8'h81, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, t0);   // mode 1, miso high
    issue(8'h81, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, t0);   // mode 2, miso high
`ifdef SPI_MASTER_X_LSB_FIRST_EN
    issue(8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, t0);
`endif

    // Stray start mid-frame, then start held from the done cycle through GAP.
    issue(8'h5A, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, t0);
    while (cyc < t0 + 5) step();
    start   = 1'b1;
    tx_data = DW'($urandom);
    cpol    = 1'b1;
    cpha    = 1'b1;
    step();
    start = 1'b0;
    while (cyc < t0 + FRAME_LEN) step();
    tx2 = DW'($urandom);
    sw2 = DW'($urandom) | DW'(1);
    cp2 = 1'($urandom);
    ch2 = 1'($urandom);
    tx_data = tx2;
    cpol    = cp2;
    cpha    = ch2;
    lsb_drv = 1'b0;
    start   = 1'b1;
    // The GAP state spans CS_GAP cycles; the accepting IDLE cycle follows.
    t0b = t0 + FRAME_LEN + GAP + 1;
    push_frame(tx2, sw2, cp2, ch2, 1'b0, 1'b0, t0b);
    while (cyc < t0b) step();
    start = 1'b0;

    // Reset in the middle of a frame.
    issue(8'hA5, 8'h69, 1'b1, 1'b0, 1'b0, 1'b0, t0);
    while (cyc < t0 + 10) step();
    reset = 1'b1;
    sb_q.delete();
    bf_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("midreset_cs_n", cs_n, 1);
    chk("midreset_sclk", sclk, 0);
    chk("midreset_mosi", mosi, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_rx_data", rx_data, 0);
    repeat (50) step();

    for (int i = 0; i < 40; i++) begin
      bit lsb_r;
      lsb_r = 1'b0;
`ifdef SPI_MASTER_X_LSB_FIRST_EN
      lsb_r = 1'($urandom);
`endif
      repeat ($urandom_range(0, 3)) step();
      issue(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), lsb_r, t0);
    end

    wait_idle();
    repeat (5) step();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
